// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the 7-segment scan controller:
//     scan_state_t   - per-slot scan phase (BLANK anti-ghosting gap, SHOW digit lit)
//     HEX_SEG_TABLE  - hex nibble -> {g,f,e,d,c,b,a}, active-high (1 = segment lit)
//     SEG_OFF        - active-high pattern with every segment unlit
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry n is HEX_SEG_TABLE[n]; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg
//   Combinational hex nibble to 7-segment decoder, active-high output.
//   Ports:
//     nibble  in   4   hex digit
//     seg     out  7   {g,f,e,d,c,b,a}, 1 = lit
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for an N-digit 7-segment display. Each digit
//   slot is SCAN_DIV cycles: BLANK_CYCLES with every digit off (segments already
//   driving the upcoming digit) then the digit enabled. New values arrive over a
//   valid/ready handshake into a one-deep pending register and are moved into the
//   display register only at a frame boundary, so a frame never tears.
//
//   Optional build macro LEADING_ZERO_BLANK_EN: digits above the most significant
//   nonzero nibble drive unlit segments (dp still shown); digit 0 always shown.
//
//   Ports:
//     clk          in   1             system clock
//     rst_n        in   1             synchronous active-low reset
//     value_in     in   4*NUM_DIGITS  hex nibbles, [3:0] = digit 0 (rightmost)
//     dp_in        in   NUM_DIGITS    decimal point per digit
//     value_valid  in   1             value_in/dp_in offered
//     value_ready  out  1             pending slot free
//     seg_out      out  7             {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//     dp_out       out  1             decimal point segment
//     dig_en       out  NUM_DIGITS    one-hot digit enable, polarity per DIG_ACTIVE_LOW
//     frame_start  out  1             pulse on first cycle of digit 0 blank slot
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLANK_CYCLES   = 50,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t            state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       cnt;

    logic [VAL_W-1:0]       display;
    logic [NUM_DIGITS-1:0]  display_dp;
    logic [VAL_W-1:0]       pending;
    logic [NUM_DIGITS-1:0]  pending_dp;
    logic                   pending_full;

    logic                   accept;
    logic                   boundary;
    logic                   capture;
    logic                   pending_full_nxt;
    logic [VAL_W-1:0]       display_nxt;
    logic [NUM_DIGITS-1:0]  display_dp_nxt;

    logic [3:0]             cur_nibble;
    logic                   cur_dp;
    logic [6:0]             cur_seg_raw;
    logic [6:0]             cur_seg;
    logic                   cur_blank;
    logic [NUM_DIGITS-1:0]  dig_onehot;

    // Handshake and frame-boundary update of the display register.
    always_comb begin
        accept           = value_valid & value_ready;
        boundary         = (state == BLANK) && (idx == '0) && (cnt == '0);
        display_nxt      = display;
        display_dp_nxt   = display_dp;
        pending_full_nxt = pending_full;
        capture          = 1'b0;

        if (boundary && pending_full) begin
            display_nxt      = pending;
            display_dp_nxt   = pending_dp;
            pending_full_nxt = 1'b0;
        end else if (boundary && accept) begin
            // Empty pending at the boundary: bypass straight into display.
            display_nxt    = value_in;
            display_dp_nxt = dp_in;
        end else if (accept) begin
            capture          = 1'b1;
            pending_full_nxt = 1'b1;
        end
    end

    // Select the digit being scanned. Uses display_nxt so the segments registered
    // at a frame boundary already reflect the newly loaded value.
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        dig_onehot = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = display_nxt[4*i +: 4];
                cur_dp     = display_dp_nxt[i];
                dig_onehot[i] = (state == SHOW);
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Blank digit idx when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx) && (display_nxt[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        cur_blank = (idx != '0) && upper_zero;
    end
`else
    always_comb begin
        cur_blank = 1'b0;
    end
`endif

    hex_to_7seg u_hex_to_7seg (
        .nibble (cur_nibble),
        .seg    (cur_seg_raw)
    );

    always_comb begin
        cur_seg = cur_blank ? SEG_OFF : cur_seg_raw;
    end

    // Scan FSM. Outputs are registered from the current slot position, so they
    // trail the position registers by exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BLANK;
            idx          <= '0;
            cnt          <= '0;
            display      <= '0;
            display_dp   <= '0;
            pending      <= '0;
            pending_dp   <= '0;
            pending_full <= 1'b0;
            value_ready  <= 1'b1;
            frame_start  <= 1'b0;
            dig_en       <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            seg_out      <= {7{SEG_ACTIVE_LOW}};
            dp_out       <= SEG_ACTIVE_LOW;
        end else begin
            display      <= display_nxt;
            display_dp   <= display_dp_nxt;
            if (capture) begin
                pending    <= value_in;
                pending_dp <= dp_in;
            end
            pending_full <= pending_full_nxt;
            value_ready  <= ~pending_full_nxt;

            frame_start  <= boundary;
            dig_en       <= DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
            seg_out      <= SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
            dp_out       <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;

            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                    end
                    cnt <= cnt + 1'b1;
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
